// File: rtl/logo_motion_sequencer.sv
// Bouncing / gamepad-steered logo position sequencer.
// One five-state pass per frame; outputs commit atomically.
module logo_motion_sequencer #(
  parameter int LOGO_SIZE      = 128,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int INIT_X         = 200,
  parameter int INIT_Y         = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vpos,
  input  logic       btn_start,
  input  logic       btn_select,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       pause,
  output logic [9:0] logo_left,
  output logic [9:0] logo_top,
  output logic [2:0] color_index,
  output logic       manual_mode,
  output logic [1:0] speed,
  output logic       bounce,
  output logic       update_done
);

  localparam logic [10:0] MAX_X =
    11'(DISPLAY_WIDTH - LOGO_SIZE);
  localparam logic [10:0] MAX_Y =
    11'(DISPLAY_HEIGHT - LOGO_SIZE);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SAMPLE = 3'd1;
  localparam logic [2:0] MOVE_X = 3'd2;
  localparam logic [2:0] MOVE_Y = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  logic [2:0]  state;
  logic [9:0]  vpos_q;
  logic        frame_tick;
  logic        cap_start, cap_select, cap_pause;
  logic        cap_up, cap_down, cap_left, cap_right;
  logic        prev_start, prev_select;
  logic        dir_x, dir_y;
  logic        nd_x, nd_y, hit_x, hit_y;
  logic [10:0] nx_x, nx_y;
  logic [10:0] step;
  logic [12:0] ax_x, ax_y;

  // Returns {hit, dir, pos} for one axis.
  function automatic logic [12:0] step_axis(
    input logic [10:0] pos,
    input logic        dir,
    input logic        dec,
    input logic        inc,
    input logic        man,
    input logic        frz,
    input logic [10:0] s,
    input logic [10:0] lim
  );
    logic [10:0] p;
    logic        d;
    logic        h;
    p = pos;
    d = dir;
    h = 1'b0;
    if (!frz) begin
      if (man) begin
        if (dec && !inc)
          p = (pos < s) ? 11'd0 : pos - s;
        else if (inc && !dec)
          p = (pos + s > lim) ? lim : pos + s;
      end else begin
        if (dec)
          d = 1'b0;
        else if (inc)
          d = 1'b1;
        if (d) begin
          if (pos + s >= lim) begin
            p = lim;
            d = 1'b0;
            h = 1'b1;
          end else begin
            p = pos + s;
          end
        end else begin
          if (pos <= s) begin
            p = 11'd0;
            d = 1'b1;
            h = 1'b1;
          end else begin
            p = pos - s;
          end
        end
      end
    end
    return {h, d, p};
  endfunction

  assign frame_tick = (vpos == 10'd0) &&
                      (vpos_q != 10'd0);
  assign step = {9'd0, speed} + 11'd1;

  assign ax_x = step_axis({1'b0, logo_left}, dir_x,
                          cap_left, cap_right,
                          manual_mode, cap_pause,
                          step, MAX_X);
  assign ax_y = step_axis({1'b0, logo_top}, dir_y,
                          cap_up, cap_down,
                          manual_mode, cap_pause,
                          step, MAX_Y);

  // Previous-line register for frame start detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vpos_q <= 10'd0;
    else       vpos_q <= vpos;
  end

  // Frame FSM, shadow computation and atomic commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cap_start   <= 1'b0;
      cap_select  <= 1'b0;
      cap_pause   <= 1'b0;
      cap_up      <= 1'b0;
      cap_down    <= 1'b0;
      cap_left    <= 1'b0;
      cap_right   <= 1'b0;
      prev_start  <= 1'b0;
      prev_select <= 1'b0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b0;
      nd_x        <= 1'b1;
      nd_y        <= 1'b0;
      hit_x       <= 1'b0;
      hit_y       <= 1'b0;
      nx_x        <= 11'd0;
      nx_y        <= 11'd0;
      logo_left   <= 10'(INIT_X);
      logo_top    <= 10'(INIT_Y);
      color_index <= 3'd0;
      manual_mode <= 1'b0;
      speed       <= 2'd0;
      bounce      <= 1'b0;
      update_done <= 1'b0;
    end else begin
      bounce      <= 1'b0;
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) state <= SAMPLE;
        end
        SAMPLE: begin
          prev_start  <= cap_start;
          prev_select <= cap_select;
          cap_start   <= btn_start;
          cap_select  <= btn_select;
          cap_pause   <= pause;
          cap_up      <= btn_up;
          cap_down    <= btn_down;
          cap_left    <= btn_left;
          cap_right   <= btn_right;
          state       <= MOVE_X;
        end
        MOVE_X: begin
          hit_x <= ax_x[12];
          nd_x  <= ax_x[11];
          nx_x  <= ax_x[10:0];
          state <= MOVE_Y;
        end
        MOVE_Y: begin
          hit_y <= ax_y[12];
          nd_y  <= ax_y[11];
          nx_y  <= ax_y[10:0];
          state <= COMMIT;
        end
        COMMIT: begin
          logo_left <= nx_x[9:0];
          logo_top  <= nx_y[9:0];
          dir_x     <= nd_x;
          dir_y     <= nd_y;
          if (hit_x || hit_y)
            color_index <= color_index + 3'd1;
          if (cap_start && !prev_start)
            manual_mode <= ~manual_mode;
          if (cap_select && !prev_select)
            speed <= speed + 2'd1;
          bounce      <= hit_x | hit_y;
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logo_motion_sequencer.sv
// Directed bench for logo_motion_sequencer.
// Linear scenario list with immediate assertions.
module tb_logo_motion_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] vpos;
  logic       btn_start, btn_select, btn_up;
  logic       btn_down, btn_left, btn_right;
  logic       pause;
  logic [9:0] logo_left, logo_top;
  logic [2:0] color_index;
  logic       manual_mode;
  logic [1:0] speed;
  logic       bounce, update_done;

  int vecs  = 0;
  int fails = 0;
  int lat;
  int got;
  int seen;
  int last_bounce;

  localparam logic [5:0] B_NONE   = 6'b000000;
  localparam logic [5:0] B_START  = 6'b100000;
  localparam logic [5:0] B_SELECT = 6'b010000;
  localparam logic [5:0] B_UD     = 6'b001100;
  localparam logic [5:0] B_LEFT   = 6'b000010;
  localparam logic [5:0] B_RIGHT  = 6'b000001;
  localparam logic [5:0] B_LR     = 6'b000011;

  always #5 clk = ~clk;

  logo_motion_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .vpos        (vpos),
    .btn_start   (btn_start),
    .btn_select  (btn_select),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .pause       (pause),
    .logo_left   (logo_left),
    .logo_top    (logo_top),
    .color_index (color_index),
    .manual_mode (manual_mode),
    .speed       (speed),
    .bounce      (bounce),
    .update_done (update_done)
  );

  task automatic chk(input string tag,
                     input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    vpos  = 10'd0;
    {btn_start, btn_select, btn_up,
     btn_down, btn_left, btn_right} = B_NONE;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [5:0] b,
                           input logic p);
    {btn_start, btn_select, btn_up,
     btn_down, btn_left, btn_right} = b;
    pause = p;
    @(negedge clk) vpos = 10'd1;
    @(negedge clk) vpos = 10'd0;
    lat = 0;
    got = 0;
    while (got == 0 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (update_done) got = 1;
    end
    if (got == 0) chk("update_timeout", got, 1);
    last_bounce = int'(bounce);
  endtask

  initial begin
    reset = 1'b1;
    vpos  = 10'd0;
    pause = 1'b0;
    {btn_start, btn_select, btn_up,
     btn_down, btn_left, btn_right} = B_NONE;
    #12;
    chk("rst_left", logo_left, 200);
    chk("rst_top", logo_top, 200);
    chk("rst_color", color_index, 0);
    chk("rst_manual", manual_mode, 0);
    chk("rst_speed", speed, 0);
    chk("rst_bounce", bounce, 0);
    chk("rst_done", update_done, 0);

    do_reset();
    run_frame(B_NONE, 1'b0);
    chk("f1_latency", lat, 5);
    chk("f1_left", logo_left, 201);
    chk("f1_top", logo_top, 199);
    chk("f1_bounce", last_bounce, 0);

    for (int f = 2; f <= 199; f++)
      run_frame(B_NONE, 1'b0);
    chk("f199_top", logo_top, 1);
    chk("f199_color", color_index, 0);
    run_frame(B_NONE, 1'b0);
    chk("f200_top", logo_top, 0);
    chk("f200_left", logo_left, 400);
    chk("f200_bounce", last_bounce, 1);
    chk("f200_color", color_index, 1);
    run_frame(B_NONE, 1'b0);
    chk("f201_top", logo_top, 1);
    chk("f201_left", logo_left, 401);
    chk("f201_bounce", last_bounce, 0);
    for (int f = 202; f <= 311; f++)
      run_frame(B_NONE, 1'b0);
    run_frame(B_NONE, 1'b0);
    chk("f312_left", logo_left, 512);
    chk("f312_bounce", last_bounce, 1);
    chk("f312_color", color_index, 2);
    run_frame(B_NONE, 1'b0);
    chk("f313_left", logo_left, 511);

    do_reset();
    run_frame(B_SELECT, 1'b0);
    chk("sel_speed", speed, 1);
    chk("sel_left", logo_left, 201);
    run_frame(B_NONE, 1'b0);
    chk("sel_next_left", logo_left, 203);
    chk("sel_hold_speed", speed, 1);

    do_reset();
    run_frame(B_START, 1'b0);
    chk("start_manual", manual_mode, 1);
    chk("start_left", logo_left, 201);
    chk("start_top", logo_top, 199);
    for (int f = 0; f < 200; f++)
      run_frame(B_LEFT, 1'b0);
    chk("man_left_walk", logo_left, 1);
    chk("man_top_still", logo_top, 199);
    chk("man_still_on", manual_mode, 1);
    run_frame(B_SELECT, 1'b1);
    run_frame(B_NONE, 1'b1);
    run_frame(B_SELECT, 1'b1);
    run_frame(B_NONE, 1'b1);
    run_frame(B_SELECT, 1'b1);
    chk("pause_speed3", speed, 3);
    chk("pause_left", logo_left, 1);
    run_frame(B_LEFT, 1'b0);
    chk("man_clamp0", logo_left, 0);
    chk("man_clamp_bnc", last_bounce, 0);
    chk("man_clamp_col", color_index, 0);
    run_frame(B_RIGHT, 1'b0);
    chk("man_right", logo_left, 4);
    run_frame(B_LR, 1'b0);
    chk("man_lr_hold", logo_left, 4);
    run_frame(B_UD, 1'b0);
    chk("man_ud_hold", logo_top, 199);

    do_reset();
    run_frame(B_SELECT, 1'b1);
    chk("p_latency", lat, 5);
    chk("p_left", logo_left, 200);
    chk("p_top", logo_top, 200);
    chk("p_color", color_index, 0);
    chk("p_speed", speed, 1);
    chk("p_bounce", last_bounce, 0);

    do_reset();
    run_frame(B_NONE, 1'b0);
    chk("pre_rst_left", logo_left, 201);
    @(negedge clk) vpos = 10'd1;
    @(negedge clk) vpos = 10'd0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_left", logo_left, 200);
    chk("mid_rst_top", logo_top, 200);
    chk("mid_rst_done", update_done, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_nopulse", update_done, 0);
    @(negedge clk) reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (update_done) seen = 1;
    end
    chk("no_tick_after_rst", seen, 0);
    run_frame(B_NONE, 1'b0);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_left", logo_left, 201);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule

// File: doc/logo_motion_sequencer.md
LOGO_MOTION_SEQUENCER -- requirements
Module: logo_motion_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- LOGO_SIZE, 128, logo edge in pixels
- DISPLAY_WIDTH, 640, visible width
- DISPLAY_HEIGHT, 480, visible height
- INIT_X, 200, reset left
- INIT_Y, 200, reset top

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; one clock, all logic on its rising edge
- reset, in, 1, asynchronous, active-high
- vpos, in, 10, current VGA line from sync generator
- btn_start / btn_select / btn_up / btn_down / btn_left / btn_right, in, 1 each, debounced gamepad levels
- pause, in, 1, freeze motion level
- logo_left / logo_top, out, 10 each, committed logo position
- color_index, out, 3, bounce colour counter
- manual_mode, out, 1, 1 = gamepad steering
- speed, out, 2, step = speed+1 px/frame
- bounce, out, 1, one-cycle pulse: edge hit this frame
- update_done, out, 1, one-cycle pulse: frame update committed

Function
REQ-003 The block SHALL register vpos into vpos_q each cycle and SHALL form frame_tick = (vpos==0) && (vpos_q!=0).
REQ-004 The FSM SHALL have states IDLE, SAMPLE, MOVE_X, MOVE_Y, COMMIT.
- IDLE->SAMPLE on frame_tick.
- SAMPLE->MOVE_X->MOVE_Y->COMMIT->IDLE unconditionally.
- frame_tick outside IDLE SHALL be ignored.
REQ-005 SAMPLE SHALL capture all buttons and pause; all later states SHALL use only the captured values.
REQ-006 Rising edges of start and select SHALL be detected against the previous frame's captured value, not per cycle.
REQ-007 MOVE_X/MOVE_Y SHALL compute next values in shadow registers; logo_left, logo_top, color_index, manual_mode, speed SHALL change only on the edge leaving COMMIT (atomic).
REQ-008 update_done SHALL be high exactly the cycle after COMMIT (5th cycle after the frame_tick cycle). bounce SHALL be high in that same cycle only if a hit occurred.
REQ-009 Limits: MAX_X = DISPLAY_WIDTH-LOGO_SIZE (512); MAX_Y = DISPLAY_HEIGHT-LOGO_SIZE (352). Step s = speed+1. All arithmetic SHALL be 11-bit to avoid wrap.
REQ-010 Auto mode direction override from captured buttons before moving:
- left sets dir_x=0, else right sets dir_x=1
- up sets dir_y=0, else down sets dir_y=1
REQ-011 Auto-mode axis update, X shown (Y identical with MAX_Y):
- dir=1: if pos+s >= MAX_X then pos=MAX_X, dir=0, hit; else pos+s.
- dir=0: if pos <= s then pos=0, dir=1, hit; else pos-s.
REQ-012 On any hit in a frame, color_index SHALL increment by exactly 1 (mod 8); a corner hit counts once.
REQ-013 Manual mode:
- left: pos=max(pos-s,0); right: pos=min(pos+s,MAX_X); same for up/down on Y.
- Both of a pair pressed: no motion on that axis.
- No hits, no colour change, dir unchanged.
REQ-014 Start edge SHALL toggle manual_mode at COMMIT; the movement in that frame uses the old mode.
REQ-015 Select edge SHALL increment speed mod 4 at COMMIT; the new step applies from the next frame.
REQ-016 With pause captured high:
- position, dir and color_index SHALL hold; bounce SHALL be 0.
- start/select edges SHALL still be processed and update_done SHALL still pulse.

Reset
REQ-017 Reset assertion SHALL asynchronously force the following, in any state including mid-update, discarding shadow values:
- FSM=IDLE, logo_left=INIT_X, logo_top=INIT_Y, dir_x=1, dir_y=0
- color_index=0, manual_mode=0, speed=0, bounce=0, update_done=0
- vpos_q=0, captured button history=0
REQ-018 After reset release, the first frame_tick SHALL require vpos to be nonzero then zero.

Verification
REQ-019 Reset, sweep vpos 1->0, no buttons -> update_done 5 cycles after tick; left=201, top=199, bounce=0.
REQ-020 Free-run 200 frames -> frame 200: top=0, dir_y=1, left=400, bounce=1, color_index=1; frame 312: left=512, dir_x=0, color_index=2.
REQ-021 Select pulsed in one frame -> speed=1 after that frame; next frame left advances by 2.
REQ-022 Start edge, then speed=3, left=1, hold left -> left=0, bounce=0, color unchanged; left+right held -> left unchanged.
REQ-023 pause high plus select edge -> position/colour frozen, speed increments, update_done pulses.
REQ-024 Assert reset during COMMIT -> outputs immediately at reset values, no update_done pulse.
